// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing unit.
// Purely declarative; no timing or flow-control behaviour of its own.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_e;

    localparam int REG_ADR_W            = 5;
    localparam int WAIT_CNT_W           = 16;
    localparam int DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID source register produced by a load in EX.
// Combinational, zero latency; register 0 never matches.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADR_W-1:0] ID_Rs,
    input  logic [REG_ADR_W-1:0] ID_Rt,
    input  logic                 ID_UsesRt,
    input  logic                 IDEX_MemRead,
    input  logic [REG_ADR_W-1:0] IDEX_RegWriteAdr,
    output logic                 LoadUse
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit  = (IDEX_RegWriteAdr == ID_Rs);
    assign rt_hit  = ID_UsesRt && (IDEX_RegWriteAdr == ID_Rt);
    assign LoadUse = IDEX_MemRead && (IDEX_RegWriteAdr != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage write-enable/flush sequencer: load-use bubbles, branch flushes, memory freeze.
// Controls are combinational from state; a pending data-memory access freezes every stage.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_ADR_W-1:0] ID_Rs,
    input  logic [REG_ADR_W-1:0] ID_Rt,
    input  logic                 ID_UsesRt,
    input  logic                 IDEX_MemRead,
    input  logic [REG_ADR_W-1:0] IDEX_RegWriteAdr,
    input  logic                 EX_BranchTaken,
    input  logic                 EXMEM_MemAccess,
    input  logic                 DMEM_Ready,
    output logic                 DMEM_Req,
    output logic                 PC_WriteEn,
    output logic                 IFID_WriteEn,
    output logic                 IDEX_WriteEn,
    output logic                 EXMEM_WriteEn,
    output logic                 MEMWB_WriteEn,
    output logic                 IFID_Flush,
    output logic                 IDEX_Flush,
    output logic                 Fault,
    output logic [CNT_W-1:0]     StallCount
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(DMEM_TIMEOUT);

    state_e                state_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0]      stall_cnt_q;
    logic [CNT_W-1:0]      stall_cnt_d;
    logic                  fault_q;
    logic                  load_use;
    logic                  frozen;

    hazard_detect u_hazard_detect (
        .ID_Rs            (ID_Rs),
        .ID_Rt            (ID_Rt),
        .ID_UsesRt        (ID_UsesRt),
        .IDEX_MemRead     (IDEX_MemRead),
        .IDEX_RegWriteAdr (IDEX_RegWriteAdr),
        .LoadUse          (load_use)
    );

    assign frozen = (state_q == FAULT)
                 || ((state_q == MEM_WAIT) && !DMEM_Ready)
                 || ((state_q == RUN) && EXMEM_MemAccess && !DMEM_Ready);

    // Reset overrides everything so the pipeline is held even before the first edge.
    always_comb begin
        DMEM_Req      = 1'b0;
        PC_WriteEn    = 1'b0;
        IFID_WriteEn  = 1'b0;
        IDEX_WriteEn  = 1'b0;
        EXMEM_WriteEn = 1'b0;
        MEMWB_WriteEn = 1'b0;
        IFID_Flush    = 1'b0;
        IDEX_Flush    = 1'b0;
        if (!rst) begin
            DMEM_Req = EXMEM_MemAccess && (state_q != FAULT);
            if (!frozen) begin
                IDEX_WriteEn  = 1'b1;
                EXMEM_WriteEn = 1'b1;
                MEMWB_WriteEn = 1'b1;
                if (EX_BranchTaken) begin
                    PC_WriteEn   = 1'b1;
                    IFID_WriteEn = 1'b1;
                    IFID_Flush   = 1'b1;
                    IDEX_Flush   = 1'b1;
                end else if (load_use) begin
                    IDEX_Flush   = 1'b1;
                end else begin
                    PC_WriteEn   = 1'b1;
                    IFID_WriteEn = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_WriteEn && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            case (state_q)
                RUN: begin
                    if (EXMEM_MemAccess && !DMEM_Ready) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= WAIT_CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (DMEM_Ready) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
                    end
                end
                FAULT:   state_q <= FAULT;
                default: state_q <= RUN;
            endcase
        end
    end

    assign Fault      = fault_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, memory freeze, timeout fault, async reset.
// A second narrow-counter instance shares the stimulus to exercise StallCount saturation.
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_wadr;
    logic       id_usesrt, idex_memread, ex_br, exmem_acc, dmem_rdy;

    logic        req, pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_fl, idex_fl, fault;
    logic [15:0] sc;
    logic        s_req, s_pc_we, s_ifid_we, s_idex_we, s_exmem_we, s_memwb_we, s_ifid_fl, s_idex_fl, s_fault;
    logic [1:0]  s_sc;
    logic [7:0]  ctl, s_ctl;

    int passed = 0;
    int total  = 0;

    // Bit order: PC, IFID, IDEX, EXMEM, MEMWB write enables, IFID/IDEX flush, DMEM_Req.
    localparam logic [7:0] C_RUN  = 8'hF8;
    localparam logic [7:0] C_RUNQ = 8'hF9;
    localparam logic [7:0] C_LU   = 8'h3A;
    localparam logic [7:0] C_BR   = 8'hFE;
    localparam logic [7:0] C_FRZ  = 8'h01;
    localparam logic [7:0] C_OFF  = 8'h00;

    assign ctl   = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_fl, idex_fl, req};
    assign s_ctl = {s_pc_we, s_ifid_we, s_idex_we, s_exmem_we, s_memwb_we, s_ifid_fl, s_idex_fl, s_req};

    always #5 clk = ~clk;

    pipeline_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_usesrt),
        .IDEX_MemRead(idex_memread), .IDEX_RegWriteAdr(idex_wadr), .EX_BranchTaken(ex_br),
        .EXMEM_MemAccess(exmem_acc), .DMEM_Ready(dmem_rdy), .DMEM_Req(req),
        .PC_WriteEn(pc_we), .IFID_WriteEn(ifid_we), .IDEX_WriteEn(idex_we),
        .EXMEM_WriteEn(exmem_we), .MEMWB_WriteEn(memwb_we), .IFID_Flush(ifid_fl),
        .IDEX_Flush(idex_fl), .Fault(fault), .StallCount(sc)
    );

    pipeline_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_usesrt),
        .IDEX_MemRead(idex_memread), .IDEX_RegWriteAdr(idex_wadr), .EX_BranchTaken(ex_br),
        .EXMEM_MemAccess(exmem_acc), .DMEM_Ready(dmem_rdy), .DMEM_Req(s_req),
        .PC_WriteEn(s_pc_we), .IFID_WriteEn(s_ifid_we), .IDEX_WriteEn(s_idex_we),
        .EXMEM_WriteEn(s_exmem_we), .MEMWB_WriteEn(s_memwb_we), .IFID_Flush(s_ifid_fl),
        .IDEX_Flush(s_idex_fl), .Fault(s_fault), .StallCount(s_sc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic usesrt,
                         input logic memread, input logic [4:0] wadr, input logic br,
                         input logic acc, input logic rdy);
        id_rs = rs; id_rt = rt; id_usesrt = usesrt; idex_memread = memread;
        idex_wadr = wadr; ex_br = br; exmem_acc = acc; dmem_rdy = rdy;
    endtask

    // Check the combinational controls mid-cycle, then advance one clock edge.
    task automatic cyc(input string tag, input logic [7:0] exp);
        #1;
        chk(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        #2;
        chk("reset_ctl", 32'(ctl), 32'(C_OFF));
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_sc", 32'(sc), 32'd0);
        #1 rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("idle", C_RUN);
        chk("idle_sc", 32'(sc), 32'd0);

        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs", C_LU);
        chk("lu_rs_sc", 32'(sc), 32'd1);
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("lu_r0", C_RUN);
        chk("lu_r0_sc", 32'(sc), 32'd1);

        drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        cyc("rt_unused", C_RUN);
        drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        cyc("rt_used", C_LU);
        chk("rt_used_sc", 32'(sc), 32'd2);
        chk("sat_sc2", 32'(s_sc), 32'd2);

        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc("br_over_lu", C_BR);
        chk("br_sc", 32'(sc), 32'd2);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc("zero_wait", C_RUNQ);
        chk("zero_wait_sc", 32'(sc), 32'd2);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("mw_frz1", C_FRZ);
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc("mw_frz2_br", C_FRZ);
        cyc("mw_frz3_br", C_FRZ);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc("mw_adv", C_RUNQ);
        chk("mw_sc", 32'(sc), 32'd5);
        chk("sat_sc3", 32'(s_sc), 32'd3);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("mw_after", C_RUN);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("to_w1", C_FRZ);
        cyc("to_w2", C_FRZ);
        cyc("to_w3", C_FRZ);
        cyc("to_w4", C_FRZ);
        chk("to_nofault", 32'(fault), 32'd0);
        cyc("to_w5", C_FRZ);
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_sc", 32'(sc), 32'd10);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc("fault_frz1", C_OFF);
        cyc("fault_frz2", C_OFF);
        chk("fault_sc", 32'(sc), 32'd12);
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("sat_fault", 32'({s_fault, s_ctl, s_sc}), 32'({1'b1, C_OFF, 2'd3}));

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_ctl", 32'(ctl), 32'(C_OFF));
        @(posedge clk);
        #1 rst = 1'b0;
        cyc("post_rst_run", C_RUN);
        chk("post_rst_sc", 32'(sc), 32'd0);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("aw_frz1", C_FRZ);
        cyc("aw_frz2", C_FRZ);
        #2 rst = 1'b1;
        #1;
        chk("aw_ctl", 32'(ctl), 32'(C_OFF));
        chk("aw_sc", 32'(sc), 32'd0);
        #1 rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("aw_run", C_RUN);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
